addr4u_retry_checker: RTL

//   Sequential front/back end for a 4-bit unsigned combinational adder (5-bit sum). Accepts
//   an operand pair, drives the external adder twice (A+B, then swapped B+A), compares the
//   two sums, retries on mismatch and emits a checked sum plus an error flag.

---
 rtl/addr4u_retry_checker_pkg.sv | 11 +
 rtl/addr4u_settle_timer.sv | 18 +
 rtl/addr4u_retry_checker.sv | 92 +++++++++
 3 files changed

// File: rtl/addr4u_retry_checker_pkg.sv
// addr4u_chk_pkg: shared widths, FSM state encoding and retry-counter width helper
// for the addr4u retry checker.
package addr4u_chk_pkg;
   localparam int OPW  = 4;
   localparam int SUMW = 5;
   typedef enum logic [2:0] {IDLE, RUN1, RUN2, CMP, OUT} state_t;
   // Never zero bits wide, even with no retries allowed.
   function automatic int retry_w(input int max_retry);
      return (max_retry < 1) ? 1 : $clog2(max_retry + 1);
   endfunction
endpackage

// File: rtl/addr4u_settle_timer.sv
// addr4u_settle_timer: loadable down-counter; done is high during the last of
// SETTLE_CYC cycles following a load.
module addr4u_settle_timer #(
   parameter int SETTLE_CYC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   output logic done
);
   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   logic [CW-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= CW'(SETTLE_CYC - 1);
      else if (load) cnt <= CW'(SETTLE_CYC - 1);
      else if (cnt != '0) cnt <= cnt - 1'b1;
   assign done = (cnt == '0);
endmodule

// File: rtl/addr4u_retry_checker.sv
// addr4u_retry_checker: drives an external 4-bit adder with A+B then B+A, retries on
// disagreement. Optional saturating error counter under macro ADDR4U_ERR_CNT_EN.
module addr4u_retry_checker
   import addr4u_chk_pkg::*;
#(
   parameter  int SETTLE_CYC = 1,
   parameter  int MAX_RETRY  = 2,
   localparam int RW         = retry_w(MAX_RETRY)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [OPW-1:0]  in_a,
   input  logic [OPW-1:0]  in_b,
   output logic [OPW-1:0]  add_a,
   output logic [OPW-1:0]  add_b,
   input  logic [SUMW-1:0] add_sum,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SUMW-1:0] out_sum,
   output logic            out_err,
   output logic [RW-1:0]   out_retries
`ifdef ADDR4U_ERR_CNT_EN
   ,
   output logic [7:0]      err_count
`endif
);
   state_t          state;
   logic [OPW-1:0]  a_q, b_q;
   logic [SUMW-1:0] s1, s2;
   logic [RW-1:0]   cnt;
   logic            run, done, retry;
   assign run       = (state == RUN1) || (state == RUN2);
   assign retry     = (s1 != s2) && (cnt < RW'(MAX_RETRY));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign add_a     = (state == RUN1) ? a_q : (state == RUN2) ? b_q : '0;
   assign add_b     = (state == RUN1) ? b_q : (state == RUN2) ? a_q : '0;
   // Reloading whenever not settling (or on a pass boundary) starts each pass fresh.
   addr4u_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
      .clk  (clk),
      .rst_n(rst_n),
      .load (!run || done),
      .done (done)
   );
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state       <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         s1          <= '0;
         s2          <= '0;
         cnt         <= '0;
         out_sum     <= '0;
         out_err     <= 1'b0;
         out_retries <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_q   <= in_a;
               b_q   <= in_b;
               cnt   <= '0;
               state <= RUN1;
            end
            RUN1: if (done) begin
               s1    <= add_sum;
               state <= RUN2;
            end
            RUN2: if (done) begin
               s2    <= add_sum;
               state <= CMP;
            end
            CMP: if (retry) begin
               cnt   <= cnt + 1'b1;
               state <= RUN1;
            end else begin
               out_sum     <= s1;
               out_err     <= (s1 != s2);
               out_retries <= cnt;
               state       <= OUT;
            end
            OUT: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
`ifdef ADDR4U_ERR_CNT_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) err_count <= '0;
      else if (state == CMP && !retry && s1 != s2 && err_count != 8'hFF) err_count <= err_count + 1'b1;
`endif
endmodule
